// File: rtl/qos_pkg.sv
// Shared constants and types for the QoS arbitration mux.
// Holds the mode selectors, FSM state encoding and default geometry.
package qos_pkg;

  localparam int QOS_MODE_STRICT = 0;
  localparam int QOS_MODE_RR     = 1;

  localparam int QOS_WIDTH = 12;
  localparam int QOS_NCH   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_STALL  = 2'd2
  } qos_state_e;

endpackage

// File: rtl/qos_arb_mux_rr_arbiter.sv
// Combinational channel picker: strict priority from index 0, or a wrapping
// search starting at rr_ptr. Produces a one-hot grant plus its index when go is set.
module rr_arbiter
  import qos_pkg::*;
#(
  parameter int NCH  = QOS_NCH,
  parameter int MODE = QOS_MODE_STRICT,
  localparam int PTR_W = $clog2(NCH)
) (
  input  logic [NCH-1:0]   req,
  input  logic [PTR_W-1:0] rr_ptr,
  input  logic             go,
  output logic [NCH-1:0]   grant,
  output logic [PTR_W-1:0] grant_idx
);

  logic [PTR_W-1:0] base;
  logic [PTR_W-1:0] cand;
  logic             found;

  assign base = (MODE == QOS_MODE_RR) ? rr_ptr : '0;

  // NOTE: every variable written in a combinational block gets a default at the
  // top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = PTR_W'((int'(base) + k) % NCH);
      if (go && !found && req[cand]) begin
        found           = 1'b1;
        grant[cand]     = 1'b1;
        grant_idx       = cand;
      end
    end
  end

endmodule

// File: rtl/qos_arb_mux.sv
// Arbitrates NCH FWFT class FIFOs into one downstream FIFO: drives pops,
// registers the granted word with a valid strobe and keeps per-channel grant counts.
module qos_arb_mux
  import qos_pkg::*;
#(
  parameter int WIDTH = QOS_WIDTH,
  parameter int NCH   = QOS_NCH,
  parameter int MODE  = QOS_MODE_STRICT,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic [NCH-1:0]       fifo_empty,
  input  logic [NCH*WIDTH-1:0] fifo_data,
  input  logic                 dst_almost_full,
  input  logic                 enable,
  output logic [NCH-1:0]       pop,
  output logic [WIDTH-1:0]     data_out,
  output logic                 valid_out,
  output logic [NCH*CNT_W-1:0] grant_cnt
);

  localparam int PTR_W = $clog2(NCH);

  logic [NCH-1:0]            req;
  logic                      any_req;
  logic                      go;
  logic [NCH-1:0]            grant;
  logic [PTR_W-1:0]          grant_idx;
  logic [PTR_W-1:0]          rr_ptr;
  logic [NCH-1:0][WIDTH-1:0] fifo_word;
  logic [NCH-1:0][CNT_W-1:0] cnt_q;
  qos_state_e                state_q, state_d;

  assign req       = ~fifo_empty;
  assign any_req   = |req;
  assign go        = enable & ~dst_almost_full & any_req;
  assign fifo_word = fifo_data;
  assign grant_cnt = cnt_q;

  rr_arbiter #(
    .NCH  (NCH),
    .MODE (MODE)
  ) u_arbiter (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .go        (go),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Pops must be quiet while reset is held, even though grants are combinational.
  assign pop = reset_L ? grant : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= go;
      if (go) data_out <= fifo_word[grant_idx];
    end
  end

  // NOTE: counters and pointer are plain flops, so they take the async reset;
  // only storage arrays (none here) would be left unreset.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt_q <= '0;
    end else if (go) begin
      cnt_q[grant_idx] <= cnt_q[grant_idx] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rr_ptr <= '0;
    end else if (MODE == QOS_MODE_RR && go) begin
      rr_ptr <= (grant_idx == PTR_W'(NCH - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // The state only tracks traffic conditions; grants never wait on it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (go)           state_d = ST_ACTIVE;
        else if (any_req) state_d = ST_STALL;
      end
      ST_ACTIVE: begin
        if (!any_req)     state_d = ST_IDLE;
        else if (!go)     state_d = ST_STALL;
      end
      ST_STALL: begin
        if (go)           state_d = ST_ACTIVE;
        else if (!any_req) state_d = ST_IDLE;
      end
      default:            state_d = ST_IDLE;
    endcase
  end

endmodule
